// File: rtl/keyboard_matrix_pkg.sv
// Shared constants for the ZX keyboard matrix: special-key Y codes,
// default parameter values and the serial frame length helper.
package keyboard_matrix_pkg;

  localparam int DEF_ROWS             = 8;
  localparam int DEF_COLS             = 5;
  localparam int DEF_AX_BITS          = 4;
  localparam int DEF_AY_BITS          = 3;
  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_WATCHDOG_CYCLES  = 0;
  localparam int DEF_RESET_MIN_CYCLES = 1024;

  // Y codes of the hotkey lines when the X field MSB is set
  localparam int Y_MAGIC = 5;
  localparam int Y_RESET = 6;
  localparam int Y_PAUSE = 7;

  function automatic int frame_len(input int ax_bits, input int ay_bits);
    return ax_bits + ay_bits;
  endfunction

endpackage

// File: rtl/serial_edge_sync.sv
// Multi-flop synchroniser for one asynchronous MCU line, with the
// synchronised level and a one-cycle rising-edge pulse.
module serial_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/keyboard_matrix_sync.sv
// Clocked ZX keyboard matrix fed by HIDman serial frames (DAT/SK/STB),
// answering port #FE reads, with watchdog release and RESET stretching.
module keyboard_matrix_sync
  import keyboard_matrix_pkg::*;
#(
  parameter int ROWS             = DEF_ROWS,
  parameter int COLS             = DEF_COLS,
  parameter int AX_BITS          = DEF_AX_BITS,
  parameter int AY_BITS          = DEF_AY_BITS,
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int WATCHDOG_CYCLES  = DEF_WATCHDOG_CYCLES,
  parameter int RESET_MIN_CYCLES = DEF_RESET_MIN_CYCLES
) (
  input  logic            CLK,
  input  logic            rst_in,
  input  logic            DAT,
  input  logic            SK,
  input  logic            STB,
  input  logic [15:0]     A,
  input  logic            M1,
  input  logic            RD,
  input  logic            IORQ,
  output logic [COLS-1:0] D,
  output logic            IORQGE,
  output logic            enable,
  output logic            PAUSE,
  output logic            MAGIC,
  output logic            RESET,
  output logic            frame_err,
  output logic            wdt_fired
);

  localparam int FRAME_LEN = frame_len(AX_BITS, AY_BITS);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int RST_W     = $clog2(RESET_MIN_CYCLES + 1);

  logic w_dat, w_sk_rise, w_stb_rise;
  logic w_dat_rise_unused, w_sk_level_unused, w_stb_level_unused;
  logic w_addr_unused;

  serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clk(CLK), .rst_n(rst_in), .i_async(DAT),
    .o_level(w_dat), .o_rise(w_dat_rise_unused)
  );

  serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sk_sync (
    .clk(CLK), .rst_n(rst_in), .i_async(SK),
    .o_level(w_sk_level_unused), .o_rise(w_sk_rise)
  );

  serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk(CLK), .rst_n(rst_in), .i_async(STB),
    .o_level(w_stb_level_unused), .o_rise(w_stb_rise)
  );

  logic [CNT_W-1:0]     r_bit_cnt;
  logic [FRAME_LEN-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_wdt_fired;

  logic [AX_BITS-1:0] w_frame_x;
  logic [AY_BITS-1:0] w_frame_y;
  logic               w_frame_valid;
  logic               w_is_special;
  logic               w_key_pressed;
  logic               w_matrix_wr;
  logic               w_magic_wr, w_reset_wr, w_pause_wr;
  logic               w_reset_press;
  logic               w_wdt_hit;

  // Y field arrives first, so it ends up in the upper bits of the shifter
  assign w_frame_x     = r_shift[AX_BITS-1:0];
  assign w_frame_y     = r_shift[FRAME_LEN-1 -: AY_BITS];
  assign w_frame_valid = w_stb_rise && (r_bit_cnt == CNT_W'(FRAME_LEN));
  assign w_is_special  = w_frame_x[AX_BITS-1];
  assign w_key_pressed = ~w_dat;

  assign w_matrix_wr = w_frame_valid && !w_is_special &&
                       (int'(w_frame_x) < ROWS) && (int'(w_frame_y) < COLS);
  assign w_magic_wr  = w_frame_valid && w_is_special && (int'(w_frame_y) == Y_MAGIC);
  assign w_reset_wr  = w_frame_valid && w_is_special && (int'(w_frame_y) == Y_RESET);
  assign w_pause_wr  = w_frame_valid && w_is_special && (int'(w_frame_y) == Y_PAUSE);
  assign w_reset_press = w_reset_wr && w_key_pressed;

  // A simultaneous SK edge is counted after the strobe, as bit 1 of the next frame
  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stb_rise && !w_frame_valid;
      if (w_stb_rise) begin
        r_bit_cnt <= w_sk_rise ? CNT_W'(1) : '0;
        if (w_sk_rise) r_shift <= {r_shift[FRAME_LEN-2:0], w_dat};
      end else if (w_sk_rise) begin
        r_shift <= {r_shift[FRAME_LEN-2:0], w_dat};
        if (r_bit_cnt != CNT_W'(FRAME_LEN)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  logic [ROWS-1:0][COLS-1:0] w_cell_wr;
  logic [ROWS-1:0][COLS-1:0] r_keys;

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_wr
      for (gj = 0; gj < COLS; gj++) begin : g_col_wr
        assign w_cell_wr[gi][gj] = w_matrix_wr && (int'(w_frame_x) == gi) &&
                                   (int'(w_frame_y) == gj);
      end
    end
  endgenerate

  logic r_magic_key, r_reset_key, r_pause_key;

  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) begin
      r_keys      <= '1;
      r_magic_key <= 1'b0;
      r_reset_key <= 1'b0;
      r_pause_key <= 1'b0;
    end else if (w_frame_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (w_cell_wr[r][c]) r_keys[r][c] <= w_dat;
        end
      end
      if (w_magic_wr) r_magic_key <= w_key_pressed;
      if (w_reset_wr) r_reset_key <= w_key_pressed;
      if (w_pause_wr) r_pause_key <= w_key_pressed;
    end else if (w_wdt_hit) begin
      r_keys      <= '1;
      r_magic_key <= 1'b0;
      r_reset_key <= 1'b0;
      r_pause_key <= 1'b0;
    end
  end

  generate
    if (WATCHDOG_CYCLES > 0) begin : g_wdt
      localparam int WDT_W = $clog2(WATCHDOG_CYCLES + 1);
      logic [WDT_W-1:0] r_wdt_cnt;

      // Saturates at the limit so the release fires only once per silence
      always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) begin
          r_wdt_cnt <= '0;
        end else if (w_frame_valid) begin
          r_wdt_cnt <= '0;
        end else if (r_wdt_cnt != WDT_W'(WATCHDOG_CYCLES)) begin
          r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
        end
      end

      assign w_wdt_hit = !w_frame_valid && (r_wdt_cnt == WDT_W'(WATCHDOG_CYCLES - 1));
    end else begin : g_no_wdt
      assign w_wdt_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) r_wdt_fired <= 1'b0;
    else         r_wdt_fired <= w_wdt_hit;
  end

  logic [RST_W-1:0] r_rst_cnt;
  logic             r_reset_active;

  // RESET is held low for at least RESET_MIN_CYCLES from the latest press
  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) begin
      r_rst_cnt      <= '0;
      r_reset_active <= 1'b0;
    end else if (w_reset_press) begin
      r_rst_cnt      <= '0;
      r_reset_active <= 1'b1;
    end else if (r_reset_active) begin
      if (r_rst_cnt != RST_W'(RESET_MIN_CYCLES - 1)) begin
        r_rst_cnt <= r_rst_cnt + RST_W'(1);
      end else if (!r_reset_key) begin
        r_reset_active <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col_rd
      logic [ROWS-1:0] w_row_bits;
      for (gj = 0; gj < ROWS; gj++) begin : g_row_rd
        assign w_row_bits[gj] = r_keys[gj][gi] | A[8+gj];
      end
      assign D[gi] = &w_row_bits;
    end
  endgenerate

  assign w_addr_unused = ^A[15:1];

  assign IORQGE    = ~(~A[0] & M1);
  assign enable    = ~IORQGE & ~RD & ~IORQ;
  assign MAGIC     = r_magic_key    ? 1'b0 : 1'bz;
  assign PAUSE     = r_pause_key    ? 1'b0 : 1'bz;
  assign RESET     = r_reset_active ? 1'b0 : 1'bz;
  assign frame_err = r_frame_err;
  assign wdt_fired = r_wdt_fired;

endmodule
